// File: rtl/scan_chain_loader.sv
// Streams scan-chain words from BRAM into PE-array id/row, LN and PE config strobes.
// Optional SCAN_RANGE_CHECK_EN adds a sticky scan_error flag for out-of-range PE entries.
module scan_chain_loader #(
    parameter int XBUS_NUMS        = 12,
    parameter int PE_NUMS          = 14,
    parameter int ID_LEN           = 5,
    parameter int ROW_LEN          = 4,
    parameter int ADDRESS_BITWIDTH = 32,
    parameter int DATA_BITWIDTH    = 32,
    parameter int CONFIG_BITWIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDRESS_BITWIDTH-1:0] base_addr,
    output logic                        busy,
    output logic                        done,
    output logic                        ram_req,
    input  logic                        ram_grant,
    output logic                        ram_enable,
    output logic [ADDRESS_BITWIDTH-1:0] ram_address,
    output logic [3:0]                  ram_we,
    input  logic [DATA_BITWIDTH-1:0]    ram_rdata,
    output logic                        set_id,
    output logic                        set_row,
    output logic [ID_LEN-1:0]           id_scan_in,
    output logic [ROW_LEN-1:0]          row_scan_in,
    output logic                        set_ln_info,
    output logic [XBUS_NUMS-1:0]        LN_config_in,
    output logic                        set_pe_info,
    output logic [CONFIG_BITWIDTH-1:0]  pe_config_in
`ifdef SCAN_RANGE_CHECK_EN
    ,
    output logic                        scan_error
`endif
);

    localparam int TOTAL = XBUS_NUMS * PE_NUMS;
    localparam int K_W   = $clog2(TOTAL + 2) + 1;

    localparam logic [1:0] CLS_PE  = 2'd0;
    localparam logic [1:0] CLS_LN  = 2'd1;
    localparam logic [1:0] CLS_CFG = 2'd2;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                      state, state_nxt;
    logic [K_W-1:0]              k_cnt;
    logic [ADDRESS_BITWIDTH-1:0] addr_q;
    logic                        start_acc;
    logic                        issue;
    logic                        last_issue;
    logic [1:0]                  cls_issue;

    logic                        vld_p0;
    logic [1:0]                  cls_p0;

    logic                        pe_stb_p1;
    logic                        ln_stb_p1;
    logic                        cfg_stb_p1;
    logic [ID_LEN-1:0]           id_p1;
    logic [ROW_LEN-1:0]          row_p1;
    logic [XBUS_NUMS-1:0]        ln_p1;
    logic [CONFIG_BITWIDTH-1:0]  cfg_p1;

    assign start_acc  = (state == IDLE) && start;
    assign issue      = ram_req && ram_grant;
    assign last_issue = (k_cnt == K_W'(TOTAL + 1));

    always_comb begin
        cls_issue = CLS_CFG;
        if (k_cnt < K_W'(TOTAL))
            cls_issue = CLS_PE;
        else if (k_cnt == K_W'(TOTAL))
            cls_issue = CLS_LN;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ram_req   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = FETCH;
            end
            FETCH: begin
                ram_req = 1'b1;
                if (ram_grant && last_issue)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // the PE config strobe is the final word leaving the pipe
                if (set_pe_info)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_cnt  <= '0;
            addr_q <= '0;
        end else if (start_acc) begin
            k_cnt  <= '0;
            addr_q <= base_addr;
        end else if (issue) begin
            k_cnt  <= k_cnt + K_W'(1);
            addr_q <= addr_q + ADDRESS_BITWIDTH'(4);
        end
    end

    assign ram_enable  = issue;
    assign ram_address = addr_q;
    assign ram_we      = 4'b0000;

    // p0: read issued, BRAM data arrives during the following cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p0 <= 1'b0;
            cls_p0 <= CLS_PE;
        end else begin
            vld_p0 <= issue;
            cls_p0 <= cls_issue;
        end
    end

    // p1: capture read data and raise the matching strobe for one cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pe_stb_p1  <= 1'b0;
            ln_stb_p1  <= 1'b0;
            cfg_stb_p1 <= 1'b0;
            id_p1      <= '0;
            row_p1     <= '0;
            ln_p1      <= '0;
            cfg_p1     <= '0;
        end else begin
            pe_stb_p1  <= vld_p0 && (cls_p0 == CLS_PE);
            ln_stb_p1  <= vld_p0 && (cls_p0 == CLS_LN);
            cfg_stb_p1 <= vld_p0 && (cls_p0 == CLS_CFG);
            if (vld_p0 && (cls_p0 == CLS_PE)) begin
                id_p1  <= ram_rdata[ID_LEN-1:0];
                row_p1 <= ram_rdata[ID_LEN+ROW_LEN-1:ID_LEN];
            end
            if (vld_p0 && (cls_p0 == CLS_LN))
                ln_p1 <= ram_rdata[XBUS_NUMS-1:0];
            if (vld_p0 && (cls_p0 == CLS_CFG))
                cfg_p1 <= ram_rdata[CONFIG_BITWIDTH-1:0];
        end
    end

    assign set_id       = pe_stb_p1;
    assign set_row      = pe_stb_p1;
    assign id_scan_in   = id_p1;
    assign row_scan_in  = row_p1;
    assign set_ln_info  = ln_stb_p1;
    assign LN_config_in = ln_p1;
    assign set_pe_info  = cfg_stb_p1;
    assign pe_config_in = cfg_p1;

`ifdef SCAN_RANGE_CHECK_EN
    logic range_bad;

    assign range_bad = (32'(ram_rdata[ID_LEN-1:0]) >= 32'(PE_NUMS)) ||
                       (32'(ram_rdata[ID_LEN+ROW_LEN-1:ID_LEN]) >= 32'(XBUS_NUMS));

    // flag rises alongside the offending id/row strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            scan_error <= 1'b0;
        else if (start_acc)
            scan_error <= 1'b0;
        else if (vld_p0 && (cls_p0 == CLS_PE) && range_bad)
            scan_error <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Randomized self-checking bench for scan_chain_loader against an event-schedule reference model.
module tb_scan_chain_loader;

    localparam int XB    = 2;
    localparam int PE    = 3;
    localparam int IDL   = 5;
    localparam int RWL   = 4;
    localparam int CW    = 32;
    localparam int TOTAL = XB * PE;
    localparam int NW    = TOTAL + 2;
    localparam int MAXC  = 160;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [31:0]       base_addr;
    logic              busy;
    logic              done;
    logic              ram_req;
    logic              ram_grant;
    logic              ram_enable;
    logic [31:0]       ram_address;
    logic [3:0]        ram_we;
    logic [31:0]       ram_rdata;
    logic              set_id;
    logic              set_row;
    logic [IDL-1:0]    id_scan_in;
    logic [RWL-1:0]    row_scan_in;
    logic              set_ln_info;
    logic [XB-1:0]     LN_config_in;
    logic              set_pe_info;
    logic [CW-1:0]     pe_config_in;
`ifdef SCAN_RANGE_CHECK_EN
    logic              scan_error;
`endif

    scan_chain_loader #(
        .XBUS_NUMS(XB), .PE_NUMS(PE), .ID_LEN(IDL), .ROW_LEN(RWL),
        .ADDRESS_BITWIDTH(32), .DATA_BITWIDTH(32), .CONFIG_BITWIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .ram_req(ram_req), .ram_grant(ram_grant),
        .ram_enable(ram_enable), .ram_address(ram_address), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .set_id(set_id), .set_row(set_row),
        .id_scan_in(id_scan_in), .row_scan_in(row_scan_in),
        .set_ln_info(set_ln_info), .LN_config_in(LN_config_in),
        .set_pe_info(set_pe_info), .pe_config_in(pe_config_in)
`ifdef SCAN_RANGE_CHECK_EN
        , .scan_error(scan_error)
`endif
    );

    always #5 clk = ~clk;

    int             n_vec = 0;
    int             n_err = 0;
    logic [31:0]    words [NW];
    bit             gnt [MAXC];
    int             rd_cyc [NW];
    logic [IDL-1:0] m_id;
    logic [RWL-1:0] m_row;
    logic [XB-1:0]  m_ln;
    logic [CW-1:0]  m_cfg;
    bit             m_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit entry_bad(input logic [31:0] w);
        return (int'(w[IDL-1:0]) >= PE) || (int'(w[IDL+RWL-1:IDL]) >= XB);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] base, input logic [31:0] a);
        logic [31:0] off;
        off = a - base;
        if (off[1:0] == 2'b00 && (off >> 2) < 32'(NW))
            return words[off >> 2];
        return 32'hDEAD_0000 ^ a;
    endfunction

    task automatic model_reset();
        m_id = '0; m_row = '0; m_ln = '0; m_cfg = '0; m_err = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, ".busy"}, 64'(busy), 64'(0));
        chk({tag, ".done"}, 64'(done), 64'(0));
        chk({tag, ".req"}, 64'(ram_req), 64'(0));
        chk({tag, ".en"}, 64'(ram_enable), 64'(0));
        chk({tag, ".addr"}, 64'(ram_address), 64'(0));
        chk({tag, ".strobes"}, 64'({set_id, set_row, set_ln_info, set_pe_info}), 64'(0));
        chk({tag, ".data"}, 64'({id_scan_in, row_scan_in, LN_config_in}), 64'(0));
        chk({tag, ".cfg"}, 64'(pe_config_in), 64'(0));
`ifdef SCAN_RANGE_CHECK_EN
        chk({tag, ".err"}, 64'(scan_error), 64'(0));
`endif
    endtask

    // mode: 0 grant always, 1 grant low in cycles 3..5, 2 random grant
    task automatic run_load(input logic [31:0] base, input int mode, input bit legal,
                            input int restart_cyc, input int abort_cyc, input int bad_word);
        int          cnt;
        int          done_c;
        int          nrd;
        int          sj;
        bit          prev_en;
        logic [31:0] prev_addr;
        bit          exp_req;
        bit          exp_en;
        logic [31:0] exp_addr;
        logic [31:0] w;

        for (int j = 0; j < NW; j++) begin
            w = $urandom;
            if (j < TOTAL && legal) begin
                w[IDL-1:0]       = IDL'($urandom_range(PE - 1, 0));
                w[IDL+RWL-1:IDL] = RWL'($urandom_range(XB - 1, 0));
            end
            words[j] = w;
        end
        if (bad_word >= 0)
            words[bad_word][IDL+RWL-1:IDL] = RWL'(XB);

        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       gnt[c] = 1'b1;
                1:       gnt[c] = !(c >= 3 && c <= 5);
                default: gnt[c] = (c >= 100) || ($urandom_range(9, 0) < 7);
            endcase
        end

        cnt = 0;
        for (int c = 1; c < MAXC; c++) begin
            if (gnt[c] && cnt < NW) begin
                rd_cyc[cnt] = c;
                cnt++;
            end
        end
        done_c = rd_cyc[NW-1] + 3;

        nrd       = 0;
        prev_en   = 1'b0;
        prev_addr = '0;
        for (int n = 0; n <= done_c + 2; n++) begin
            @(posedge clk);
            #1;
            start     = (n == 0) || (n == restart_cyc);
            base_addr = (n == 0) ? base : $urandom;
            ram_grant = gnt[n];
            ram_rdata = prev_en ? mem_rd(base, prev_addr) : $urandom;
            if (n == abort_cyc) begin
                rst = 1'b0;
                #1;
                check_reset_outs("abort");
                model_reset();
                @(negedge clk);
                rst   = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clk);

            exp_req  = (n >= 1) && (n <= rd_cyc[NW-1]);
            exp_en   = exp_req && gnt[n];
            exp_addr = base + 32'(4 * nrd);
            chk("req", 64'(ram_req), 64'(exp_req));
            chk("en", 64'(ram_enable), 64'(exp_en));
            chk("busy", 64'(busy), 64'((n >= 1) && (n <= done_c)));
            chk("done", 64'(done), 64'(n == done_c));
            chk("we", 64'(ram_we), 64'(0));
            if (exp_en) begin
                chk("addr", 64'(ram_address), 64'(exp_addr));
                nrd++;
            end
            prev_en   = exp_en;
            prev_addr = exp_addr;

            sj = -1;
            for (int j = 0; j < NW; j++)
                if (rd_cyc[j] + 2 == n) sj = j;
            if (n == 1) m_err = 1'b0;
            if (sj >= 0 && sj < TOTAL) begin
                m_id  = words[sj][IDL-1:0];
                m_row = words[sj][IDL+RWL-1:IDL];
                if (entry_bad(words[sj])) m_err = 1'b1;
            end
            if (sj == TOTAL)     m_ln  = words[sj][XB-1:0];
            if (sj == TOTAL + 1) m_cfg = words[sj][CW-1:0];

            chk("set_id", 64'(set_id), 64'(sj >= 0 && sj < TOTAL));
            chk("set_row", 64'(set_row), 64'(sj >= 0 && sj < TOTAL));
            chk("set_ln", 64'(set_ln_info), 64'(sj == TOTAL));
            chk("set_pe", 64'(set_pe_info), 64'(sj == TOTAL + 1));
            chk("id", 64'(id_scan_in), 64'(m_id));
            chk("row", 64'(row_scan_in), 64'(m_row));
            chk("ln", 64'(LN_config_in), 64'(m_ln));
            chk("cfg", 64'(pe_config_in), 64'(m_cfg));
`ifdef SCAN_RANGE_CHECK_EN
            if (n >= 1)
                chk("scan_err", 64'(scan_error), 64'(m_err));
`endif
        end
        start = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        ram_grant = 1'b0;
        base_addr = '0;
        ram_rdata = '0;
        model_reset();
        #1;
        check_reset_outs("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run_load(32'h0000_0100, 0, 1'b1, -1, -1, -1);
        run_load(32'h0000_0100, 1, 1'b1, -1, -1, -1);
        run_load(32'h0000_0100, 0, 1'b1,  4, -1, -1);
        run_load(32'h0000_0100, 0, 1'b0, -1,  5, -1);
        run_load(32'h0000_0100, 0, 1'b1, -1, -1, -1);
        run_load(32'hFFFF_FFFC, 0, 1'b1, -1, -1, -1);
        run_load(32'h0000_0100, 0, 1'b1, -1, -1,  2);
        run_load(32'h0000_0100, 0, 1'b1, -1, -1, -1);
        for (int t = 0; t < 8; t++)
            run_load($urandom, 2, 1'($urandom_range(1, 0)), -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_chain_loader.md
Name: scan_chain_loader

Overview:
Sequencer that configures the PE array before a layer runs. It streams scan-chain words from BRAM starting at a base address and converts them into the PE array's configuration strobes: per-PE id/row shifts, the X-bus LN config and the PE config word. It shares the BRAM read port with the top-level controller through a req/grant handshake. It sits between the controller (start/done) and the PE array scan inputs.

Parameters:
XBUS_NUMS, 12, number of X-buses (rows); also the LN_config_in width
PE_NUMS, 14, PEs per X-bus
ID_LEN, 5, width of the PE id scan field
ROW_LEN, 4, width of the row scan field
ADDRESS_BITWIDTH, 32, BRAM byte-address width
DATA_BITWIDTH, 32, BRAM word width (must be >= ID_LEN+ROW_LEN and >= XBUS_NUMS)
CONFIG_BITWIDTH, 32, PE config word width (must be <= DATA_BITWIDTH)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse; accepted only in IDLE
base_addr  in  ADDRESS_BITWIDTH  byte address of word 0 (scalar7_config); sampled on accepted start
busy  out  1  high while loading
done  out  1  one-cycle completion pulse
ram_req  out  1  read port requested
ram_grant  in  1  port granted this cycle
ram_enable  out  1  read strobe = ram_req & ram_grant
ram_address  out  ADDRESS_BITWIDTH  base + 4*k
ram_we  out  4  tied 4'b0000
ram_rdata  in  DATA_BITWIDTH  read data, valid 1 cycle after ram_enable
set_id, set_row  out  1  id/row shift strobes (asserted together)
id_scan_in  out  ID_LEN  rdata[ID_LEN-1:0]
row_scan_in  out  ROW_LEN  rdata[ID_LEN+ROW_LEN-1:ID_LEN]
set_ln_info  out  1  LN config strobe
LN_config_in  out  XBUS_NUMS  rdata[XBUS_NUMS-1:0]
set_pe_info  out  1  PE config strobe
pe_config_in  out  CONFIG_BITWIDTH  rdata[CONFIG_BITWIDTH-1:0]

Behaviour:
- TOTAL = XBUS_NUMS*PE_NUMS; words 0..TOTAL-1 = PE entries (word 0 shifted first), word TOTAL = LN config, word TOTAL+1 = PE config.
- States: IDLE, FETCH, DRAIN, DONE.
- Reset (rst low, any state, immediate): IDLE; issue counter k=0; all strobes, busy, done, ram_req = 0; data outputs = 0; in-flight read discarded.
- IDLE: start -> FETCH, latch base_addr, k=0. start in any other state ignored.
- FETCH: ram_req=1. Each cycle with ram_grant=1: read word k at base_addr+4*k (ADDRESS_BITWIDTH modulo wrap), k++. ram_grant=0 stalls with no read and no k change; back-to-back grants stream one word/cycle. After word TOTAL+1 is issued -> DRAIN, ram_req=0 from that next cycle.
- Read issued cycle c: rdata captured at edge ending c+1; matching strobe high in cycle c+2 for exactly one cycle with data outputs registered alongside; data outputs hold until next strobe.
- Strobe select by word index: <TOTAL -> set_id+set_row; ==TOTAL -> set_ln_info; ==TOTAL+1 -> set_pe_info. Never more than one strobe class per cycle.
- DRAIN: wait until set_pe_info cycle -> DONE. DONE: done=1 one cycle -> IDLE.
- busy=1 in FETCH, DRAIN, DONE; 0 in IDLE.
- Minimum load with continuous grant: start at cycle 0, first read cycle 1, set_pe_info cycle TOTAL+4, done TOTAL+5.
- Grant dropping mid-stream gaps strobes correspondingly; no words lost or duplicated.

Optional Feature:
SCAN_RANGE_CHECK_EN: adds output scan_error (1 bit). Set when a PE entry has id field >= PE_NUMS or row field >= XBUS_NUMS; sticky, cleared on accepted start and reset; loading continues unchanged. Without macro: port absent, no checking logic.

Test Plan:
- XBUS_NUMS=2, PE_NUMS=3, base 0x100, grant always 1, start cycle 0 -> reads 0x100..0x11C cycles 1-8; set_id/set_row cycles 3-8 carrying words 0-5; set_ln_info cycle 9; set_pe_info cycle 10; done cycle 11.
- Same, grant low cycles 3-5 -> reads pause, strobes gap 3 cycles, done cycle 14, all 8 words delivered in order.
- start asserted again at cycle 4 of a load -> ignored; exactly 8 reads, one done pulse.
- rst low during FETCH at cycle 5 -> same cycle all outputs 0, busy 0; subsequent start performs full load from word 0.
- base 0xFFFFFFFC -> word 1 read at 0x00000000 (wrap).
- SCAN_RANGE_CHECK_EN, word 2 row field=2 (XBUS_NUMS=2) -> scan_error rises by cycle 6, stays high through done, clears on next start.
